// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - serial pattern transmitter: 4-bit code in, 8-bit pattern out MSB first
// Two-process FSM (IDLE/SEND/GAP) with an optional idle gap and a wrapping frame counter.
module sequence_generator #(
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] code,
  output logic       ready,
  output logic       x,
  output logic       x_valid,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] frames_sent
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic       x_q, x_d;
  logic       x_valid_q, x_valid_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] frames_q, frames_d;
  logic       code_valid;
  logic [7:0] code_pattern;

  function automatic logic [7:0] pattern_of(input logic [3:0] c);
    case (c)
      4'd1:    return 8'b11110000;
      4'd2:    return 8'b11001100;
      4'd3:    return 8'b00110011;
      4'd4:    return 8'b00001111;
      default: return 8'b00000000;
    endcase
  endfunction

  assign code_valid   = (code >= 4'd1) && (code <= 4'd4);
  assign code_pattern = pattern_of(code);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= 8'd0;
      bit_cnt_q <= 3'd0;
      gap_cnt_q <= 8'd0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      frames_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
      frames_q  <= frames_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    frames_d  = frames_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (code_valid) begin
            // The MSB goes out on the acceptance edge so the first bit lands one cycle later.
            shift_d   = code_pattern;
            bit_cnt_d = 3'd7;
            x_d       = code_pattern[7];
            x_valid_d = 1'b1;
            state_d   = SEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (bit_cnt_q == 3'd0) begin
          done_d    = 1'b1;
          frames_d  = frames_q + 8'd1;
          gap_cnt_d = 8'd0;
          state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else begin
          shift_d   = {shift_q[6:0], 1'b0};
          x_d       = shift_q[6];
          x_valid_d = 1'b1;
          bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = 8'd0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready       = (state_q == IDLE) && !rst;
  assign busy        = (state_q == SEND) || (state_q == GAP);
  assign x           = x_q;
  assign x_valid     = x_valid_q;
  assign done        = done_q;
  assign err         = err_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_sequence_generator.sv
// tb/tb_sequence_generator.sv - randomized and directed bench for sequence_generator (gap 0 and gap 3)
module tb_sequence_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] code = 4'd0;

  logic       ready0, x0, xv0, busy0, done0, err0;
  logic [7:0] fs0;
  logic       ready3, x3, xv3, busy3, done3, err3;
  logic [7:0] fs3;
  logic [27:0] obs;

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;

  // Reference timeline per instance: lock = cycles left with ready low, age = cycles since acceptance.
  int         m_lock [2];
  int         m_age  [2];
  int         m_cnt  [2];
  bit         m_errp [2];
  logic [7:0] m_pat  [2];

  always #5 clk = ~clk;

  sequence_generator #(.GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .code(code),
    .ready(ready0), .x(x0), .x_valid(xv0), .busy(busy0),
    .done(done0), .err(err0), .frames_sent(fs0)
  );

  sequence_generator #(.GAP_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .code(code),
    .ready(ready3), .x(x3), .x_valid(xv3), .busy(busy3),
    .done(done3), .err(err3), .frames_sent(fs3)
  );

  assign obs = {ready0, busy0, x0, xv0, done0, err0, fs0,
                ready3, busy3, x3, xv3, done3, err3, fs3};

  function automatic logic [7:0] spec_pattern(input logic [3:0] c);
    logic [7:0] table_v [5];
    table_v[0] = 8'h00; table_v[1] = 8'hF0; table_v[2] = 8'hCC;
    table_v[3] = 8'h33; table_v[4] = 8'h0F;
    return (c >= 1 && c <= 4) ? table_v[c] : 8'h00;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int g;
      bit ok;
      g  = (i == 0) ? 0 : 3;
      ok = (code >= 1) && (code <= 4);
      if (rst) begin
        m_lock[i] = 0; m_age[i] = 0; m_cnt[i] = 0; m_errp[i] = 0; m_pat[i] = 8'h00;
      end else begin
        m_errp[i] = (m_lock[i] == 0) && start && !ok;
        if ((m_lock[i] == 0) && start && ok) begin
          m_lock[i] = 8 + g;
          m_age[i]  = 1;
          m_pat[i]  = spec_pattern(code);
        end else begin
          if (m_lock[i] > 0) m_lock[i] = m_lock[i] - 1;
          if (m_age[i] > 0) m_age[i] = (m_age[i] == 9) ? 0 : m_age[i] + 1;
        end
        if (m_age[i] == 9) m_cnt[i] = (m_cnt[i] + 1) % 256;
      end
    end
  endtask

  function automatic logic [13:0] exp_of(input int i);
    logic xv, xb;
    xv = (m_age[i] >= 1) && (m_age[i] <= 8);
    xb = xv ? m_pat[i][8 - m_age[i]] : 1'b0;
    return {(m_lock[i] == 0) && !rst, m_lock[i] > 0, xb, xv, m_age[i] == 9, m_errp[i], 8'(m_cnt[i])};
  endfunction

  function automatic logic [27:0] expv();
    return {exp_of(0), exp_of(1)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; code = 4'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; code = 4'd1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++;
      if (obs !== expv()) begin
        n_err++; $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
    end
    n_chk++;
    if ({ready0, busy0, x0, xv0, done0, err0, fs0} !== 14'd0) begin
      n_err++; $display("FAIL reset_values got=%h exp=0", {ready0, busy0, x0, xv0, done0, err0, fs0});
    end
    rst = 1'b0; start = 1'b0;
    tick();
    n_chk++;
    if (ready0 !== 1'b1 || ready3 !== 1'b1) begin
      n_err++; $display("FAIL reset_ready got=%b%b exp=11", ready0, ready3);
    end
  endtask

  task automatic test_code1();
    logic [7:0] bits = 8'h00;
    int nb = 0;
    do_reset();
    start = 1'b1; code = 4'd1;
    for (int k = 0; k < 14; k++) begin
      tick();
      start = 1'b0;
      n_chk++;
      if (obs !== expv()) begin
        n_err++; $display("FAIL code1 cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
      if (xv0) begin bits = {bits[6:0], x0}; nb++; end
      if (k == 8) begin
        n_chk++;
        if (done0 !== 1'b1 || fs0 !== 8'd1) begin
          n_err++; $display("FAIL code1_done got=%b/%0d exp=1/1", done0, fs0);
        end
      end
    end
    n_chk++;
    if (bits !== 8'hF0 || nb != 8) begin
      n_err++; $display("FAIL code1_bits got=%h/%0d exp=f0/8", bits, nb);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] list [3];
    logic [23:0] bits = 24'd0;
    int nb = 0, idx = 0;
    list[0] = 4'd2; list[1] = 4'd3; list[2] = 4'd4;
    do_reset();
    start = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (m_lock[0] == 0) begin
        if (idx < 3) begin code = list[idx]; idx++; end
        else start = 1'b0;
      end
      tick();
      n_chk++;
      if (obs !== expv()) begin
        n_err++; $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
      if (xv0) begin bits = {bits[22:0], x0}; nb++; end
    end
    start = 1'b0;
    n_chk++;
    if (bits !== 24'hCC330F || nb != 24 || fs0 !== 8'd3) begin
      n_err++; $display("FAIL b2b_line got=%h/%0d/%0d exp=cc330f/24/3", bits, nb, fs0);
    end
  endtask

  task automatic test_invalid();
    int errs = 0;
    bit saw_xv = 0, saw_nready = 0;
    do_reset();
    start = 1'b1; code = 4'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      code = 4'd9;
      if (k >= 1) start = 1'b0;
      n_chk++;
      if (obs !== expv()) begin
        n_err++; $display("FAIL invalid cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
      errs += int'(err0);
      saw_xv |= xv0;
      saw_nready |= !ready0;
    end
    n_chk++;
    if (errs != 2 || saw_xv || saw_nready || fs0 !== 8'd0) begin
      n_err++; $display("FAIL invalid_summary got=err%0d xv%0b nr%0b fs%0d exp=err2 xv0 nr0 fs0", errs, saw_xv, saw_nready, fs0);
    end
  endtask

  task automatic test_gap();
    int last = -1, nstarts = 0;
    bit prev = 0;
    do_reset();
    start = 1'b1;
    for (int k = 0; k < 50; k++) begin
      code = 4'($urandom_range(1, 4));
      tick();
      n_chk++;
      if (obs !== expv()) begin
        n_err++; $display("FAIL gap cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
      if (xv3 && !prev) begin
        if (last >= 0) begin
          n_chk++;
          if (cyc - last != 12) begin
            n_err++; $display("FAIL gap_period got=%0d exp=12", cyc - last);
          end
        end
        last = cyc; nstarts++;
      end
      prev = xv3;
    end
    start = 1'b0;
    n_chk++;
    if (nstarts < 4) begin
      n_err++; $display("FAIL gap_starts got=%0d exp>=4", nstarts);
    end
  endtask

  task automatic test_ignore_busy();
    int errs = 0;
    do_reset();
    start = 1'b1; code = 4'd1;
    for (int k = 0; k < 14; k++) begin
      tick();
      start = (k >= 2 && k <= 6);
      code  = (k == 2) ? 4'd2 : 4'($urandom_range(0, 15));
      n_chk++;
      if (obs !== expv()) begin
        n_err++; $display("FAIL ignore cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
      errs += int'(err0);
    end
    start = 1'b0;
    n_chk++;
    if (errs != 0 || fs0 !== 8'd1) begin
      n_err++; $display("FAIL ignore_summary got=err%0d fs%0d exp=err0 fs1", errs, fs0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] bits = 8'h00;
    do_reset();
    start = 1'b1; code = 4'd1;
    for (int k = 0; k < 4; k++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b1;
    tick();
    n_chk++;
    if ({x0, xv0, busy0, done0, fs0, x3, xv3, busy3, done3, fs3} !== 24'd0 || obs !== expv()) begin
      n_err++; $display("FAIL reset_mid got=%h exp=%h", obs, expv());
    end
    rst = 1'b0;
    tick();
    start = 1'b1; code = 4'd4;
    for (int k = 0; k < 10; k++) begin
      tick();
      start = 1'b0;
      n_chk++;
      if (obs !== expv()) begin
        n_err++; $display("FAIL reset_mid_after cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
      if (xv0) bits = {bits[6:0], x0};
    end
    n_chk++;
    if (bits !== 8'h0F || fs0 !== 8'd1) begin
      n_err++; $display("FAIL reset_mid_frame got=%h/%0d exp=0f/1", bits, fs0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rst   = ($urandom_range(0, 49) == 0);
      start = $urandom_range(0, 1);
      code  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      tick();
      n_chk++;
      if (obs !== expv()) begin
        n_err++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
    end
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_wrap();
    int dones = 0;
    bit reached = 0;
    do_reset();
    start = 1'b1;
    for (int k = 0; k < 3000 && !reached; k++) begin
      code = 4'($urandom_range(1, 4));
      tick();
      n_chk++;
      if (obs !== expv()) begin
        n_err++; $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
      if (done0) begin
        dones++;
        if (dones == 256) begin
          reached = 1;
          n_chk++;
          if (fs0 !== 8'd0) begin
            n_err++; $display("FAIL wrap_value got=%0d exp=0", fs0);
          end
        end
      end
    end
    start = 1'b0;
    if (!reached) begin
      n_chk++; n_err++;
      $display("FAIL wrap_timeout got=%0d dones exp=256", dones);
    end
  endtask

  initial begin
    test_reset();
    test_code1();
    test_back_to_back();
    test_invalid();
    test_gap();
    test_ignore_busy();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sequence_generator.md
# sequence_generator

Serial pattern transmitter: accepts a 4-bit pattern code and drives the matching 8-bit pattern onto a single-bit line, MSB first, one bit per clock. It is the source end of the serial pattern link whose receiving end is the sequence detector. Code 1 sends 8'b11110000, code 2 sends 8'b11001100, code 3 sends 8'b00110011 and code 4 sends 8'b00001111. An optional idle gap is inserted after each frame, and a running count of frames sent is kept.

## Interface
- GAP_CYCLES, default 0: idle cycles inserted after each frame before the next start is accepted (range 0..255).
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to send a frame; sampled only while ready=1.
- code  input  4  pattern code, sampled together with start.
- ready  output  1  block idle and accepting start; combinational, equal to (state==IDLE) && !rst.
- x  output  1  serial data, registered; 0 when not sending.
- x_valid  output  1  x carries a frame bit this cycle; registered.
- busy  output  1  high in SEND and GAP states.
- done  output  1  one-cycle pulse in the cycle after the last bit of a frame.
- err  output  1  one-cycle pulse after a start with an invalid code.
- frames_sent  output  8  count of completed frames; wraps from 255 to 0.

## Operation
- States:
  - IDLE: x=0, x_valid=0, busy=0, ready=1.
  - SEND: 8 bits shifted out of an 8-bit register from the MSB; a 3-bit counter runs 7 down to 0.
  - GAP: counter runs for GAP_CYCLES cycles with x=0 and x_valid=0.
- IDLE with start=1 and code in 1..4: load the pattern into the shift register, set the bit counter to 7, go to SEND.
- IDLE with start=1 and code 0 or 5..15: stay in IDLE, pulse err for one cycle, leave frames_sent unchanged.
- SEND with the bit counter at 0: on that edge, go to GAP if GAP_CYCLES>0, otherwise to IDLE. Assert done for one cycle and increment frames_sent modulo 256.
- GAP: go to IDLE when the gap counter reaches GAP_CYCLES-1.
- start while ready=0 is ignored. It causes no err and is not queued. code is don't-care while ready=0.
- code is captured only at acceptance; changing it mid-frame has no effect.
- Reset values, applied on the first rising edge with rst=1: state IDLE, x=0, x_valid=0, busy=0, done=0, err=0, frames_sent=0, shift register and counters cleared.
- While rst=1, ready=0 and start is ignored.
- Reset mid-frame or mid-gap: the frame is aborted with no done and no count increment. The line returns to x=0 and x_valid=0 on the reset edge.

## Timing
- Cycle 0: start=1, ready=1, valid code (sampled at the end of cycle 0).
- Cycles 1..8: x_valid=1, busy=1, ready=0. x carries pattern bit 7 in cycle 1 down to bit 0 in cycle 8.
- Cycle 9:
  - x_valid=0, x=0, done=1.
  - frames_sent shows the incremented value.
  - GAP_CYCLES=0: ready=1 and busy=0. The earliest next start is sampled in cycle 9, so its first bit appears in cycle 10. Minimum frame period is 9 cycles.
  - GAP_CYCLES=G>0: busy=1 for cycles 9..8+G, and ready=1 from cycle 9+G.
- Invalid code sampled in cycle 0: err=1 in cycle 1 only, ready stays 1 throughout, and a new start may be sampled in cycle 1.
- Latency from start acceptance to first bit: 1 cycle. Latency from start acceptance to done: 9 cycles.

## Test plan
- Reset, then start with code=1: x over cycles 1..8 = 1,1,1,1,0,0,0,0 with x_valid=1; done=1 in cycle 9; frames_sent=1.
- Codes 2, 3, 4 sent back-to-back with GAP_CYCLES=0 (start held high): line shows 11001100, then 00110011, then 00001111, each preceded by exactly one x_valid=0 cycle; frames_sent=3.
- start with code=0, then code=9: err pulses one cycle each, x_valid stays 0, frames_sent unchanged, ready stays 1.
- GAP_CYCLES=3, start held high: ready low for 11 cycles after each acceptance, so frames start every 12 cycles; busy high through the gap.
- start with code=2 while a frame is in SEND, and code changed mid-frame: the current frame is unchanged, no err, no extra frame.
- rst=1 asserted at the 4th bit of a frame: on the next edge x=0, x_valid=0, busy=0, frames_sent=0, no done; after rst drops a new code=4 frame is sent correctly.
- 256 frames sent: frames_sent wraps to 0 on the 256th done.
